// File: rtl/hwpe_stream_package.sv
// Shared helpers for the HWPE stream blocks: counter sizing and byte-enable masks.
package hwpe_stream_package;

    // Widest byte-enable mask the helper can produce (2048-bit data words).
    localparam int unsigned MAX_BE_WIDTH = 256;

    // Counter width able to hold the values 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Mask with the low nbytes bits set; callers truncate to their byte-enable width.
    function automatic logic [MAX_BE_WIDTH-1:0] be_all_ones(input int unsigned nbytes);
        logic [MAX_BE_WIDTH-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_BE_WIDTH; i++) begin
            if (i < nbytes) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/hwpe_stream_fifo.sv
// Flop-based response FIFO; head word is presented straight from storage and
// forced to zero while empty so the stream output is clean out of reset.
module hwpe_stream_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Pointer/occupancy update; pop is only issued by the parent while valid_o is high.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = ptr_next(wr_ptr_q);
            end
            if (pop_i) rd_ptr_d = ptr_next(rd_ptr_q);
            if (push_i && !pop_i)      cnt_d = cnt_q + CNT_ONE;
            else if (!push_i && pop_i) cnt_d = cnt_q - CNT_ONE;
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Head word presentation.
    always_comb begin
        valid_o = (cnt_q != '0);
        data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    end

endmodule

// File: rtl/hwpe_stream_tcdm_load_buffer.sv
// TCDM load buffer: turns an address stream into TCDM reads and returns the
// read data as a stream. A credit counter (in-flight + buffered) caps issue so
// the response FIFO can never overflow regardless of response latency.
module hwpe_stream_tcdm_load_buffer
    import hwpe_stream_package::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_WIDTH  = cnt_width(DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    enable_i,
    input  logic                    addr_valid_i,
    output logic                    addr_ready_o,
    input  logic [31:0]             addr_data_i,
    output logic                    tcdm_req_o,
    input  logic                    tcdm_gnt_i,
    output logic [31:0]             tcdm_add_o,
    output logic                    tcdm_wen_o,
    output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
    output logic [DATA_WIDTH-1:0]   tcdm_data_o,
    input  logic [DATA_WIDTH-1:0]   tcdm_r_data_i,
    input  logic                    tcdm_r_valid_i,
    output logic                    data_valid_o,
    input  logic                    data_ready_i,
    output logic [DATA_WIDTH-1:0]   data_data_o,
    output logic [DATA_WIDTH/8-1:0] data_strb_o,
    output logic                    busy_o,
    output logic                    error_o
);

    localparam int unsigned BE_W = DATA_WIDTH / 8;
    localparam logic [BE_W-1:0]      BE_ONES   = BE_W'(be_all_ones(BE_W));
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(DEPTH);

    logic [CNT_WIDTH-1:0] credit_q, credit_d;
    logic [CNT_WIDTH-1:0] out_q, out_d;
    logic                 error_q, error_d;
    logic                 grant, pop, rsp_ok, rsp_spur;

    // Request path; held low during reset so nothing is issued before the counters are valid.
    always_comb begin
        tcdm_req_o   = rst_ni & addr_valid_i & enable_i & ~clear_i & (credit_q < CNT_LIMIT);
        addr_ready_o = tcdm_req_o & tcdm_gnt_i;
        tcdm_add_o   = addr_data_i;
        tcdm_wen_o   = 1'b1;
        tcdm_be_o    = BE_ONES;
        tcdm_data_o  = '0;
        grant        = addr_ready_o;
        pop          = data_valid_o & data_ready_i;
        // A response with nothing outstanding is a protocol error and is dropped;
        // anything arriving during clear is dropped silently.
        rsp_ok       = tcdm_r_valid_i & ~clear_i & (out_q != '0);
        rsp_spur     = tcdm_r_valid_i & ~clear_i & (out_q == '0);
    end

    // Credit/outstanding bookkeeping and sticky error.
    always_comb begin
        credit_d = credit_q;
        out_d    = out_q;
        error_d  = error_q | rsp_spur;
        if (clear_i) begin
            credit_d = '0;
            out_d    = '0;
            error_d  = 1'b0;
        end else begin
            if (grant && !pop)      credit_d = credit_q + CNT_ONE;
            else if (!grant && pop) credit_d = credit_q - CNT_ONE;
            if (grant && !rsp_ok)      out_d = out_q + CNT_ONE;
            else if (!grant && rsp_ok) out_d = out_q - CNT_ONE;
        end
    end

    // Counter and error registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credit_q <= '0;
            out_q    <= '0;
            error_q  <= 1'b0;
        end else begin
            credit_q <= credit_d;
            out_q    <= out_d;
            error_q  <= error_d;
        end
    end

    hwpe_stream_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (DEPTH)
    ) i_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (rsp_ok),
        .data_i  (tcdm_r_data_i),
        .pop_i   (pop),
        .valid_o (data_valid_o),
        .data_o  (data_data_o)
    );

    // Status and stream side-band.
    always_comb begin
        data_strb_o = BE_ONES;
        busy_o      = (out_q != '0) | data_valid_o;
        error_o     = error_q;
    end

endmodule

// File: tb/tb_hwpe_stream_tcdm_load_buffer.sv
// Scoreboard bench: a TCDM model answers grants in order with configurable
// latency; expected words are queued at grant time and popped on output handshakes.
module tb_hwpe_stream_tcdm_load_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni, clear_i, enable_i, addr_valid_i, tcdm_gnt_i;
    logic          tcdm_r_valid_i, data_ready_i;
    logic [31:0]   addr_data_i;
    logic [DW-1:0] tcdm_r_data_i;
    logic          addr_ready_o, tcdm_req_o, tcdm_wen_o, data_valid_o, busy_o, error_o;
    logic [31:0]   tcdm_add_o;
    logic [DW/8-1:0] tcdm_be_o, data_strb_o;
    logic [DW-1:0] tcdm_data_o, data_data_o;

    hwpe_stream_tcdm_load_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .enable_i(enable_i),
        .addr_valid_i(addr_valid_i), .addr_ready_o(addr_ready_o), .addr_data_i(addr_data_i),
        .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
        .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
        .tcdm_r_data_i(tcdm_r_data_i), .tcdm_r_valid_i(tcdm_r_valid_i),
        .data_valid_o(data_valid_o), .data_ready_i(data_ready_i), .data_data_o(data_data_o),
        .data_strb_o(data_strb_o), .busy_o(busy_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct { logic [31:0] addr; int when; } rsp_t;
    rsp_t          rsp_q[$];
    logic [DW-1:0] exp_q[$];

    int n_vec = 0, n_bad = 0;
    int lat_min = 1, lat_max = 1, last_when = 0;
    bit spur = 0;
    int gnt_cnt = 0, out_cnt = 0, first_out = -1, last_out = -1, first_hs = -1;

    function automatic logic [DW-1:0] mem_rd(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hA5C3_0F17;
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Grant monitor (feeds TCDM model + scoreboard) and output checker.
    initial begin : mon
        int w;
        logic [DW-1:0] e;
        forever begin
            @(negedge clk_i);
            if (rst_ni && tcdm_req_o && tcdm_gnt_i) begin
                w = cyc + int'($urandom_range(lat_max, lat_min));
                if (w <= last_when) w = last_when + 1;
                last_when = w;
                rsp_q.push_back('{tcdm_add_o, w});
                exp_q.push_back(mem_rd(tcdm_add_o));
                gnt_cnt++;
                if (first_hs < 0) first_hs = cyc;
            end
            if (rst_ni && data_valid_o && data_ready_i) begin
                if (exp_q.size() == 0) chk("unexpected_out", 64'(data_data_o), 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    e = exp_q.pop_front();
                    chk("out_data", data_data_o, e);
                end
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                out_cnt++;
            end
        end
    end

    // TCDM response driver: in-order, one response per cycle at most.
    initial begin
        tcdm_r_valid_i = 1'b0;
        tcdm_r_data_i  = '0;
        forever begin
            @(posedge clk_i); #1;
            tcdm_r_valid_i = 1'b0;
            tcdm_r_data_i  = '0;
            if (spur) begin
                tcdm_r_valid_i = 1'b1;
                tcdm_r_data_i  = 32'hDEAD_BEEF;
            end else if (rsp_q.size() > 0 && rsp_q[0].when == cyc) begin
                tcdm_r_valid_i = 1'b1;
                tcdm_r_data_i  = mem_rd(rsp_q[0].addr);
                void'(rsp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic stats_reset();
        first_hs = -1; first_out = -1; last_out = -1; out_cnt = 0;
    endtask

    // Present one address until handshake; caller is at posedge+1.
    task automatic send(input logic [31:0] a, input int budget);
        bit hs;
        int n;
        addr_valid_i = 1'b1;
        addr_data_i  = a;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < budget) begin
            @(negedge clk_i);
            hs = addr_ready_o;
            n++;
            @(posedge clk_i); #1;
        end
        addr_valid_i = 1'b0;
        chk("send_handshake", 64'(hs), 64'd1);
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || data_valid_o) && n < budget) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    bit done;
    int g0;

    initial begin
        rst_ni = 1'b1; clear_i = 1'b0; enable_i = 1'b1; addr_valid_i = 1'b1;
        addr_data_i = 32'h100; tcdm_gnt_i = 1'b1; data_ready_i = 1'b1;
        #1 rst_ni = 1'b0;
        #11;
        chk("rst_req", 64'(tcdm_req_o), 64'd0);
        chk("rst_addr_ready", 64'(addr_ready_o), 64'd0);
        chk("rst_valid", 64'(data_valid_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_error", 64'(error_o), 64'd0);
        chk("rst_data", 64'(data_data_o), 64'd0);
        chk("wen", 64'(tcdm_wen_o), 64'd1);
        chk("be", 64'(tcdm_be_o), 64'hF);
        chk("wdata", 64'(tcdm_data_o), 64'd0);
        chk("strb", 64'(data_strb_o), 64'hF);
        addr_valid_i = 1'b0;
        @(negedge clk_i) rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Streaming: 8 back-to-back words, 2-cycle latency, one per cycle.
        stats_reset();
        for (int i = 0; i < 8; i++) send(32'h1000 + 32'(4 * i), 20);
        drain("t1_drain", 50);
        chk("t1_count", 64'(out_cnt), 64'd8);
        chk("t1_latency", 64'(first_out - first_hs), 64'd2);
        chk("t1_consecutive", 64'(last_out - first_out), 64'd7);

        // Back-pressure: credits cap issue at DEPTH.
        stats_reset();
        data_ready_i = 1'b0;
        g0 = gnt_cnt;
        fork
            begin
                for (int i = 0; i < 6; i++) send(32'h2000 + 32'(4 * i), 60);
            end
            begin
                repeat (12) @(posedge clk_i);
                @(negedge clk_i);
                chk("t2_grants", 64'(gnt_cnt - g0), 64'd4);
                chk("t2_req_low", 64'(tcdm_req_o), 64'd0);
                chk("t2_credit", 64'(dut.credit_q), 64'd4);
                @(posedge clk_i); #1;
                data_ready_i = 1'b1;
            end
        join
        drain("t2_drain", 50);
        chk("t2_count", 64'(out_cnt), 64'd6);

        // Grant stall: address held, no handshake until grant.
        stats_reset();
        g0 = gnt_cnt;
        tcdm_gnt_i = 1'b0;
        addr_valid_i = 1'b1;
        addr_data_i = 32'h3000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("t3_no_ready", 64'(addr_ready_o), 64'd0);
            chk("t3_addr_stable", 64'(tcdm_add_o), 64'h3000);
            chk("t3_req_high", 64'(tcdm_req_o), 64'd1);
            @(posedge clk_i); #1;
        end
        tcdm_gnt_i = 1'b1;
        @(negedge clk_i);
        chk("t3_handshake", 64'(addr_ready_o), 64'd1);
        @(posedge clk_i); #1;
        addr_valid_i = 1'b0;
        @(negedge clk_i);
        chk("t3_credit", 64'(dut.credit_q), 64'd1);
        chk("t3_grants", 64'(gnt_cnt - g0), 64'd1);
        @(posedge clk_i); #1;
        drain("t3_drain", 20);

        // Random latency 1..5 with random output back-pressure.
        stats_reset();
        lat_max = 5;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 100; i++) send(32'h4000 + 32'(4 * i), 100);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk_i); #1;
                    data_ready_i = 1'($urandom_range(1, 0));
                end
            end
        join
        data_ready_i = 1'b1;
        drain("t4_drain", 400);
        lat_max = 1;
        @(negedge clk_i);
        chk("t4_count", 64'(out_cnt), 64'd100);
        chk("t4_error", 64'(error_o), 64'd0);
        chk("t4_busy", 64'(busy_o), 64'd0);

        // Spurious response sets sticky error; response during clear is silent.
        @(negedge clk_i) spur = 1'b1;
        @(negedge clk_i) spur = 1'b0;
        @(negedge clk_i);
        chk("t5_error_set", 64'(error_o), 64'd1);
        chk("t5_fifo_empty", 64'(data_valid_o), 64'd0);
        @(negedge clk_i);
        chk("t5_error_sticky", 64'(error_o), 64'd1);
        spur = 1'b1;
        @(posedge clk_i); #1;
        clear_i = 1'b1;
        @(negedge clk_i) spur = 1'b0;
        @(posedge clk_i); #1;
        clear_i = 1'b0;
        @(negedge clk_i);
        chk("t5_error_cleared", 64'(error_o), 64'd0);
        chk("t5_valid_after_clear", 64'(data_valid_o), 64'd0);
        @(posedge clk_i); #1;

        // Asynchronous reset with two words buffered.
        stats_reset();
        data_ready_i = 1'b0;
        send(32'h5000, 20);
        send(32'h5004, 20);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("t6_buffered", 64'(dut.credit_q), 64'd2);
        chk("t6_head", 64'(data_data_o), 64'(exp_q[0]));
        @(posedge clk_i); #3;
        addr_valid_i = 1'b1;
        addr_data_i  = 32'h5008;
        rst_ni = 1'b0;
        #1;
        chk("t6_valid", 64'(data_valid_o), 64'd0);
        chk("t6_busy", 64'(busy_o), 64'd0);
        chk("t6_req", 64'(tcdm_req_o), 64'd0);
        chk("t6_addr_ready", 64'(addr_ready_o), 64'd0);
        chk("t6_data", 64'(data_data_o), 64'd0);
        chk("t6_error", 64'(error_o), 64'd0);
        exp_q.delete();
        rsp_q.delete();
        addr_valid_i = 1'b0;
        data_ready_i = 1'b1;
        @(negedge clk_i) rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Recovery after reset.
        stats_reset();
        send(32'h6000, 20);
        send(32'h6004, 20);
        drain("t7_drain", 20);
        chk("t7_count", 64'(out_cnt), 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
